// File: rtl/big_core_cr_ctrl.sv
`default_nettype none
// ============================================================================
// big_core_cr_ctrl : core CR register block with synchronised/debounced inputs,
//                    W1C event flags, irq and cycle counter; debounce via
//                    MAFIA_CR_DEBOUNCE_EN.                        Rev 1.0
// ============================================================================
module big_core_cr_ctrl #(
   parameter int          NUM_SEG7   = 6,
   parameter int          LED_W      = 10,
   parameter int          SW_W       = 10,
   parameter int          NUM_BTN    = 2,
   parameter int          DEB_CYCLES = 50000,
   parameter logic [31:0] CR_BASE    = 32'h0
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [31:0]             data,
   input  logic [31:0]             address,
   input  logic                    wren,
   input  logic                    rden,
   output logic [31:0]             q,
   input  logic [31:0]             address_b,
   output logic [31:0]             q_b,
   input  logic [NUM_BTN-1:0]      Button,
   input  logic [SW_W-1:0]         Switch,
   output logic [NUM_SEG7*8-1:0]   seg7_out,
   output logic [LED_W-1:0]        led_out,
   output logic                    irq
);

   localparam int          EV_W       = NUM_BTN + 1;
   localparam logic [31:0] c_A_LED    = CR_BASE + 32'h40;
   localparam logic [31:0] c_A_SWITCH = CR_BASE + 32'h44;
   localparam logic [31:0] c_A_BUTTON = CR_BASE + 32'h48;
   localparam logic [31:0] c_A_EVENT  = CR_BASE + 32'h4C;
   localparam logic [31:0] c_A_EV_EN  = CR_BASE + 32'h50;
   localparam logic [31:0] c_A_CYCLE  = CR_BASE + 32'h54;
   localparam logic [31:0] c_A_SCRAT  = CR_BASE + 32'h58;

   logic [7:0]         r_seg7 [NUM_SEG7];
   logic [LED_W-1:0]   r_led;
   logic [EV_W-1:0]    r_event;
   logic [EV_W-1:0]    r_event_en;
   logic [31:0]        r_cycle;
   logic [31:0]        r_scratch;

   logic [NUM_BTN-1:0] r_btn_s1, r_btn_s2, r_btn_dbp;
   logic [SW_W-1:0]    r_sw_s1, r_sw_s2, r_sw_dbp;
   logic [NUM_BTN-1:0] w_btn_db;
   logic [SW_W-1:0]    w_sw_db;

   logic [EV_W-1:0]    w_ev_set;
   logic [EV_W-1:0]    w_ev_clr;
   logic [31:0]        w_rd_q;
   logic [31:0]        w_rd_b;

   // Two-flop synchronisers, plus the previous debounced value for edge detection
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_btn_s1  <= '0;
         r_btn_s2  <= '0;
         r_btn_dbp <= '0;
         r_sw_s1   <= '0;
         r_sw_s2   <= '0;
         r_sw_dbp  <= '0;
      end else begin
         r_btn_s1  <= Button;
         r_btn_s2  <= r_btn_s1;
         r_btn_dbp <= w_btn_db;
         r_sw_s1   <= Switch;
         r_sw_s2   <= r_sw_s1;
         r_sw_dbp  <= w_sw_db;
      end
   end

`ifdef MAFIA_CR_DEBOUNCE_EN
   localparam int                CNT_W      = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [NUM_BTN-1:0] r_btn_db;
   logic [SW_W-1:0]    r_sw_db;
   logic [CNT_W-1:0]   r_sw_cnt;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn_deb
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
               r_cnt        <= '0;
               r_btn_db[gi] <= 1'b0;
            end else if (r_btn_s2[gi] == r_btn_db[gi]) begin
               r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
               r_btn_db[gi] <= r_btn_s2[gi];
               r_cnt        <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   endgenerate

   // The whole switch vector shares one counter
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_sw_cnt <= '0;
         r_sw_db  <= '0;
      end else if (r_sw_s2 == r_sw_db) begin
         r_sw_cnt <= '0;
      end else if (r_sw_cnt == c_CNT_LAST) begin
         r_sw_db  <= r_sw_s2;
         r_sw_cnt <= '0;
      end else begin
         r_sw_cnt <= r_sw_cnt + CNT_W'(1);
      end
   end

   assign w_btn_db = r_btn_db;
   assign w_sw_db  = r_sw_db;
`else
   assign w_btn_db = r_btn_s2;
   assign w_sw_db  = r_sw_s2;
`endif

   always_comb begin
      w_ev_set                = '0;
      w_ev_set[NUM_BTN-1:0]   = w_btn_db & ~r_btn_dbp & r_event_en[NUM_BTN-1:0];
      w_ev_set[NUM_BTN]       = (w_sw_db != r_sw_dbp) & r_event_en[NUM_BTN];
      w_ev_clr                = '0;
      if (wren && (address == c_A_EVENT)) begin
         w_ev_clr = data[NUM_BTN:0];
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < NUM_SEG7; i++) begin
            r_seg7[i] <= '0;
         end
         r_led      <= '0;
         r_event    <= '0;
         r_event_en <= '0;
         r_cycle    <= '0;
         r_scratch  <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         // Set dominates a same-cycle clear
         r_event <= (r_event & ~w_ev_clr) | w_ev_set;
         if (wren) begin
            for (int i = 0; i < NUM_SEG7; i++) begin
               if (address == CR_BASE + 32'(4 * i)) begin
                  r_seg7[i] <= data[7:0];
               end
            end
            if (address == c_A_LED)   r_led      <= data[LED_W-1:0];
            if (address == c_A_EV_EN) r_event_en <= data[NUM_BTN:0];
            if (address == c_A_SCRAT) r_scratch  <= data;
         end
      end
   end

   function automatic logic [31:0] f_read(input logic [31:0] a);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NUM_SEG7; i++) begin
         if (a == CR_BASE + 32'(4 * i)) v = {24'h0, r_seg7[i]};
      end
      if (a == c_A_LED)    v = 32'(r_led);
      if (a == c_A_SWITCH) v = 32'(w_sw_db);
      if (a == c_A_BUTTON) v = 32'(w_btn_db);
      if (a == c_A_EVENT)  v = 32'(r_event);
      if (a == c_A_EV_EN)  v = 32'(r_event_en);
      if (a == c_A_CYCLE)  v = r_cycle;
      if (a == c_A_SCRAT)  v = r_scratch;
      return v;
   endfunction

   always_comb begin
      w_rd_q = f_read(address);
      w_rd_b = f_read(address_b);
   end

   // Both ports sample pre-edge register state, so a same-edge write is not visible
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         q   <= '0;
         q_b <= '0;
      end else begin
         q   <= rden ? w_rd_q : 32'h0;
         q_b <= w_rd_b;
      end
   end

   generate
      for (genvar gs = 0; gs < NUM_SEG7; gs++) begin : g_seg7
         assign seg7_out[8*gs +: 8] = r_seg7[gs];
      end
   endgenerate

   assign led_out = r_led;
   assign irq     = |r_event;

endmodule
`default_nettype wire
